// File: rtl/iob_fifo_wr_ctrl_pkg.sv
// iob_fifo_wr_ctrl_pkg: pointer width and reset value shared with the read-side FIFO controller.
package iob_fifo_wr_ctrl_pkg;
  localparam int PTR_RST = 0;
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/iob_sync.sv
// iob_sync: multi-flop synchronizer with clock enable, async reset and sync clear.
module iob_sync #(
  parameter int DATA_W = 1,
  parameter int STAGES = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);
  logic [STAGES-1:0][DATA_W-1:0] sync_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) sync_q <= '0;
    else if (cke_i) sync_q <= rst_i ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/iob_fifo_wr_ctrl.sv
// iob_fifo_wr_ctrl: async FIFO write-side pointer/flag controller.
// Optional occupancy output level_o enabled by macro IOB_FIFO_WR_CTRL_LEVEL_EN.
module iob_fifo_wr_ctrl
  import iob_fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic                       w_en_i,
  input  logic [ptr_w(ADDR_W)-1:0]   r_gray_i,
  output logic [ptr_w(ADDR_W)-1:0]   w_gray_o,
  output logic [ADDR_W-1:0]          w_addr_o,
  output logic                       w_accept_o,
  output logic                       full_o,
  output logic                       overflow_o
`ifdef IOB_FIFO_WR_CTRL_LEVEL_EN
  ,
  output logic [ptr_w(ADDR_W)-1:0]   level_o
`endif
);
  localparam int PW = ptr_w(ADDR_W);
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  logic [PW-1:0] rgray_s, wbin_q, wbin_d, wgray_q;
  logic          ovf_q;
  iob_sync #(.DATA_W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .d_i    (r_gray_i),
    .q_o    (rgray_s)
  );
  // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
  assign full_o     = wgray_q == (rgray_s ^ FULL_MASK);
  assign w_accept_o = w_en_i & ~full_o & cke_i;
  assign wbin_d     = wbin_q + PW'(w_accept_o);
  assign w_addr_o   = wbin_q[ADDR_W-1:0];
  assign w_gray_o   = wgray_q;
  assign overflow_o = ovf_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      wbin_q  <= PW'(PTR_RST);
      wgray_q <= PW'(PTR_RST);
      ovf_q   <= 1'b0;
    end else if (cke_i) begin
      wbin_q  <= rst_i ? PW'(PTR_RST) : wbin_d;
      wgray_q <= rst_i ? PW'(PTR_RST) : wbin_d ^ (wbin_d >> 1);
      ovf_q   <= ~rst_i & w_en_i & full_o;
    end
`ifdef IOB_FIFO_WR_CTRL_LEVEL_EN
  logic [PW-1:0] rbin_s, level_q;
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) rbin_s[i] = ^(rgray_s >> i);
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) level_q <= PW'(PTR_RST);
    else if (cke_i) level_q <= rst_i ? PW'(PTR_RST) : wbin_d - rbin_s;
  assign level_o = level_q;
`endif
endmodule

// File: doc/iob_fifo_wr_ctrl.md
IOB_FIFO_WR_CTRL -- requirements
Module: iob_fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: FIFO address width; depth is 2**ADDR_W; pointers are ADDR_W+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, range 2..4: number of synchronizer flops on the read pointer.
REQ-003 SHALL have port clk_i, input, 1 bit: write-domain clock; the block has one clock only.
REQ-004 SHALL have port arst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port cke_i, input, 1 bit: clock enable; when low, all registers hold.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous clear, active-high.
REQ-007 SHALL have port w_en_i, input, 1 bit: write request.
REQ-008 SHALL have port r_gray_i, input, ADDR_W+1 bits: Gray read pointer from the read domain (asynchronous).
REQ-009 SHALL have port w_gray_o, output, ADDR_W+1 bits: registered Gray write pointer, sent to the read domain.
REQ-010 SHALL have port w_addr_o, output, ADDR_W bits: binary RAM write address.
REQ-011 SHALL have port w_accept_o, output, 1 bit: RAM write strobe.
REQ-012 SHALL have port full_o, output, 1 bit: FIFO full.
REQ-013 SHALL have port overflow_o, output, 1 bit: one-cycle pulse marking a write rejected because the FIFO was full.
REQ-014 SHALL have port level_o, output, ADDR_W+1 bits: occupancy as seen by the write side (present only with the macro, see REQ-030).

Function
REQ-015 SHALL register r_gray_i through SYNC_STAGES flops (rgray_s); all full/level logic uses only rgray_s.
REQ-016 SHALL keep the binary write pointer wbin (ADDR_W+1 bits), and w_gray_o SHALL be a register loaded with next_wbin ^ (next_wbin >> 1).
REQ-017 SHALL assert w_accept_o = w_en_i & ~full_o & cke_i, combinationally.
REQ-018 SHALL, on an accepting edge, increment wbin by 1 modulo 2**(ADDR_W+1); the wrap from all-ones to 0 is a normal increment.
REQ-019 SHALL drive w_addr_o = wbin[ADDR_W-1:0], valid in the same cycle as w_accept_o.
REQ-020 SHALL assert full_o when w_gray_o equals rgray_s with its two MSBs inverted; full_o is derived from registers only, with no input-to-output path.
REQ-021 SHALL assert full_o in the cycle after the edge that accepts the 2**ADDR_W-th unread entry.
REQ-022 SHALL deassert full_o exactly SYNC_STAGES cycles after r_gray_i advances; there is no earlier release.
REQ-023 SHALL register overflow_o as w_en_i & full_o & cke_i, so it is high for one cycle following the rejected request; a rejected write SHALL NOT change any pointer.
REQ-024 SHALL assume r_gray_i changes by at most one bit per read-clock event; multi-bit jumps are out of contract.

Reset
REQ-025 SHALL, on arst_i high, immediately clear wbin, w_gray_o, every synchronizer flop and overflow_o, independent of clk_i and cke_i.
REQ-026 SHALL, on rst_i high at a clk_i edge with cke_i high, apply the same clear synchronously; rst_i SHALL take priority over w_en_i.
REQ-027 SHALL, in the reset state, present: w_addr_o = 0, w_gray_o = 0, full_o = 0, overflow_o = 0, level_o = 0, w_accept_o = w_en_i.
REQ-028 SHALL, on reset mid-operation, discard the stored occupancy; the read side is reset together with this block by system contract.

Configuration
REQ-029 SHALL define the macro IOB_FIFO_WR_CTRL_LEVEL_EN to gate the level feature.
REQ-030 SHALL, with the macro defined, include a Gray-to-binary conversion of rgray_s (rbin_s), a registered level_o = wbin − rbin_s modulo 2**(ADDR_W+1) updated every enabled edge, and the level_o port.
REQ-031 SHALL, without the macro, omit the level_o port, the converter and the register; all other behaviour is identical.

Structure
REQ-032 SHALL place the pointer-width constant (ADDR_W+1) and the reset value 0 in the shared FIFO header used by the read-side controller.
REQ-033 SHALL implement the synchronizer as one instance of the existing iob_sync sub-module with DATA_W = ADDR_W+1; the counters and flags SHALL be local to this block.

Verification (ADDR_W = 2, SYNC_STAGES = 2, r_gray_i held at 0 unless stated)
REQ-034 SHALL verify: arst_i pulse mid-stream -> all outputs 0 immediately, with no clk_i edge required.
REQ-035 SHALL verify: 4 consecutive writes -> w_addr_o sequence 0,1,2,3; w_gray_o sequence 001,011,010,110; full_o = 1 after the 4th edge.
REQ-036 SHALL verify: a 5th write while full -> w_accept_o = 0, overflow_o = 1 for one cycle, w_gray_o stays 110.
REQ-037 SHALL verify: with full, r_gray_i set to 001 -> full_o falls exactly 2 edges later; level_o goes 4 -> 3 (macro on).
REQ-038 SHALL verify: 8 writes interleaved with reads so r_gray_i tracks -> wbin wraps 7 -> 0, w_gray_o returns to 000, full_o is never set.
REQ-039 SHALL verify: cke_i = 0 with w_en_i = 1 -> no pointer change and w_accept_o = 0; rst_i = 1 together with w_en_i = 1 -> pointers cleared, with no increment.
